// File: rtl/fp16_raddsub_front_if.sv
// Operand/result bundle for the FP16 add/subtract front half.
// The master drives the operands and the op flag; the slave (the datapath)
// returns the raw mantissa result together with sign, exponent and special flags.
interface fp16_raddsub_front_if;
   logic [15:0] arg_0;   // operand X {sign, exp[4:0], frac[9:0]}
   logic [15:0] arg_1;   // operand Y
   logic        arg_2;   // 1 = X-Y, 0 = X+Y
   logic [21:0] ret_0;   // raw mantissa: [21] carry, [20] hidden, [19:10] frac, [9:0] guard ext
   logic        ret_1;   // result sign
   logic        ret_2;   // raw mantissa result is zero
   logic [4:0]  ret_3;   // exponent of the larger-magnitude operand
   logic        ret_4;   // either operand has exponent 31
   logic        ret_5;   // NaN result

   modport master (
      output arg_0, arg_1, arg_2,
      input  ret_0, ret_1, ret_2, ret_3, ret_4, ret_5
   );

   modport slave (
      input  arg_0, arg_1, arg_2,
      output ret_0, ret_1, ret_2, ret_3, ret_4, ret_5
   );
endinterface

// File: rtl/fp16_raddsub_front.sv
// FP16 add/subtract front half: magnitude sort, unpack/align, raw mantissa add.
// Purely combinational (latency 0). clk/rst are accepted for pipeline
// uniformity with the back half but drive no state, so the outputs follow the
// operands at all times, including while reset is asserted.
module fp16_raddsub_front (
   input  logic                 clk,
   input  logic                 rst,
   fp16_raddsub_front_if.slave  bus
);

   localparam int MANT_W = 21;   // {hidden, frac[9:0], 10 guard-extension bits}

   // clk/rst have no loads; fold them into one deliberately unused net.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   // ------------------------------------------------------------------
   // S0: sort by magnitude
   // ------------------------------------------------------------------
   logic        x_sign;
   logic        y_sign_eff;
   logic        swap;
   logic        eff_sub;
   logic        a_sign;
   logic [4:0]  a_exp;
   logic [4:0]  b_exp;
   logic [9:0]  a_frac;
   logic [9:0]  b_frac;

   // Pick A as the larger magnitude; on an exact magnitude tie X stays A.
   always_comb begin
      x_sign     = bus.arg_0[15];
      y_sign_eff = bus.arg_1[15] ^ bus.arg_2;
      swap       = (bus.arg_1[14:0] > bus.arg_0[14:0]);
      eff_sub    = x_sign ^ y_sign_eff;
      a_sign     = x_sign;
      a_exp      = bus.arg_0[14:10];
      a_frac     = bus.arg_0[9:0];
      b_exp      = bus.arg_1[14:10];
      b_frac     = bus.arg_1[9:0];
      if (swap) begin
         a_sign = y_sign_eff;
         a_exp  = bus.arg_1[14:10];
         a_frac = bus.arg_1[9:0];
         b_exp  = bus.arg_0[14:10];
         b_frac = bus.arg_0[9:0];
      end
   end

   // ------------------------------------------------------------------
   // S1: unpack and align
   // ------------------------------------------------------------------
   logic [MANT_W-1:0] a_mant;
   logic [MANT_W-1:0] b_mant;
   logic [4:0]        shift_amt;
   logic [MANT_W-1:0] lost_mask;
   logic [MANT_W-1:0] b_shifted;
   logic              b_sticky;
   logic [MANT_W-1:0] b_aligned;

   // Exponent 0 (zero or denormal) flushes to a zero mantissa; a zero B
   // takes A's exponent so it is never shifted.
   always_comb begin
      a_mant    = (a_exp == 5'd0) ? '0 : {1'b1, a_frac, 10'b0};
      b_mant    = (b_exp == 5'd0) ? '0 : {1'b1, b_frac, 10'b0};
      shift_amt = (b_exp == 5'd0) ? 5'd0 : (a_exp - b_exp);
   end

   // Bit gi of B is shifted out whenever the alignment distance exceeds gi.
   // Distances of 21 or more mark every bit as lost.
   generate
      for (genvar gi = 0; gi < MANT_W; gi++) begin : g_lost_mask
         assign lost_mask[gi] = (shift_amt > 5'(gi));
      end
   endgenerate

   // Right-shift B and collapse everything shifted out into bit 0 (sticky).
   always_comb begin
      b_shifted = b_mant >> shift_amt;
      b_sticky  = |(b_mant & lost_mask);
      b_aligned = b_shifted | {{(MANT_W-1){1'b0}}, b_sticky};
   end

   // ------------------------------------------------------------------
   // S2: raw add/subtract and result flags
   // ------------------------------------------------------------------
   logic [MANT_W:0] mant_sum;
   logic            sum_zero;
   logic            x_is_max_exp;
   logic            y_is_max_exp;
   logic            x_is_nan;
   logic            y_is_nan;
   logic            x_is_inf;
   logic            y_is_inf;
   logic            special;
   logic            nan_result;
   logic            result_sign;

   // A >= B in magnitude, so the difference can never go negative.
   always_comb begin
      if (eff_sub) begin
         mant_sum = {1'b0, a_mant} - {1'b0, b_aligned};
      end else begin
         mant_sum = {1'b0, a_mant} + {1'b0, b_aligned};
      end
      sum_zero = (mant_sum == '0);
   end

   // Classify inf/NaN operands from the raw inputs.
   always_comb begin
      x_is_max_exp = (bus.arg_0[14:10] == 5'h1F);
      y_is_max_exp = (bus.arg_1[14:10] == 5'h1F);
      x_is_nan     = x_is_max_exp && (bus.arg_0[9:0] != 10'd0);
      y_is_nan     = y_is_max_exp && (bus.arg_1[9:0] != 10'd0);
      x_is_inf     = x_is_max_exp && (bus.arg_0[9:0] == 10'd0);
      y_is_inf     = y_is_max_exp && (bus.arg_1[9:0] == 10'd0);
      special      = x_is_max_exp | y_is_max_exp;
      nan_result   = x_is_nan | y_is_nan | (x_is_inf & y_is_inf & eff_sub);
   end

   // Sign selection. An inf/NaN operand always sorts as A, so A's sign covers
   // the special case. An exact zero from cancellation is +0; a zero from an
   // effective add only arises from two same-signed zeros and keeps that sign.
   always_comb begin
      result_sign = a_sign;
      if (!special && sum_zero) begin
         result_sign = eff_sub ? 1'b0 : x_sign;
      end
   end

   // Drive the result bundle.
   always_comb begin
      bus.ret_0 = mant_sum;
      bus.ret_1 = result_sign;
      bus.ret_2 = sum_zero;
      bus.ret_3 = a_exp;
      bus.ret_4 = special;
      bus.ret_5 = nan_result;
   end

endmodule

// File: tb/tb_fp16_raddsub_front.sv
// Directed bench for the FP16 add/subtract front half.
// Each step applies one operand pair and checks the outputs against
// hand-computed values; one line is printed per transaction.
module tb_fp16_raddsub_front;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fp16_raddsub_front_if bus ();

   fp16_raddsub_front dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one operand pair and compare every output. When chk_mant is 0
   // (inf/NaN operands) ret_0, ret_2 and ret_3 are don't-care and skipped.
   task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic op, input logic chk_mant,
                       input logic [21:0] e0, input logic e1, input logic e2,
                       input logic [4:0] e3, input logic e4, input logic e5);
      @(posedge clk);
      bus.arg_0 = x;
      bus.arg_1 = y;
      bus.arg_2 = op;
      @(negedge clk);
      $display("%s: x=%04h y=%04h op=%0d -> ret_0=%06h ret_1=%0d ret_2=%0d ret_3=%0d ret_4=%0d ret_5=%0d",
               tag, x, y, op, bus.ret_0, bus.ret_1, bus.ret_2, bus.ret_3, bus.ret_4, bus.ret_5);
      if (chk_mant) begin
         checks++;
         assert (bus.ret_0 === e0) else begin
            errors++;
            $error("FAIL %s ret_0 observed=%06h expected=%06h", tag, bus.ret_0, e0);
         end
         checks++;
         assert (bus.ret_2 === e2) else begin
            errors++;
            $error("FAIL %s ret_2 observed=%0d expected=%0d", tag, bus.ret_2, e2);
         end
         checks++;
         assert (bus.ret_3 === e3) else begin
            errors++;
            $error("FAIL %s ret_3 observed=%0d expected=%0d", tag, bus.ret_3, e3);
         end
      end
      checks++;
      assert (bus.ret_1 === e1) else begin
         errors++;
         $error("FAIL %s ret_1 observed=%0d expected=%0d", tag, bus.ret_1, e1);
      end
      checks++;
      assert (bus.ret_4 === e4) else begin
         errors++;
         $error("FAIL %s ret_4 observed=%0d expected=%0d", tag, bus.ret_4, e4);
      end
      checks++;
      assert (bus.ret_5 === e5) else begin
         errors++;
         $error("FAIL %s ret_5 observed=%0d expected=%0d", tag, bus.ret_5, e5);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      bus.arg_0 = 16'h0000;
      bus.arg_1 = 16'h0000;
      bus.arg_2 = 1'b0;

      //    tag            X        Y        op    chk   ret_0       s     z     exp    sp    nan
      step("zero_rst",   16'h0000, 16'h0000, 1'b0, 1'b1, 22'h000000, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0);
      rst = 1'b0;
      step("one_p_one",  16'h3C00, 16'h3C00, 1'b0, 1'b1, 22'h200000, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0);
      step("one_m_one",  16'h3C00, 16'h3C00, 1'b1, 1'b1, 22'h000000, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0);
      step("two_m_three",16'h4000, 16'h4200, 1'b1, 1'b1, 22'h080000, 1'b1, 1'b0, 5'd16, 1'b0, 1'b0);
      step("d14_align",  16'h3C00, 16'h0400, 1'b0, 1'b1, 22'h100040, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0);
      step("d29_sticky", 16'h7800, 16'h0400, 1'b0, 1'b1, 22'h100001, 1'b0, 1'b0, 5'd30, 1'b0, 1'b0);
      step("d11_sticky", 16'h6800, 16'h3C01, 1'b1, 1'b1, 22'h0FFDFF, 1'b0, 1'b0, 5'd26, 1'b0, 1'b0);
      step("swap_add",   16'h3C00, 16'h3C01, 1'b0, 1'b1, 22'h200400, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0);
      step("neg_two_p1", 16'hC000, 16'h3C00, 1'b0, 1'b1, 22'h080000, 1'b1, 1'b0, 5'd16, 1'b0, 1'b0);
      step("nz_p_nz",    16'h8000, 16'h8000, 1'b0, 1'b1, 22'h000000, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0);
      step("nz_m_nz",    16'h8000, 16'h8000, 1'b1, 1'b1, 22'h000000, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0);
      step("denorm_ftz", 16'h0001, 16'h8001, 1'b0, 1'b1, 22'h000000, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0);
      step("inf_m_inf",  16'h7C00, 16'h7C00, 1'b1, 1'b0, 22'h000000, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1);
      step("inf_p_one",  16'h7C00, 16'h3C00, 1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0);
      step("inf_p_inf",  16'h7C00, 16'h7C00, 1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0);
      step("ninf_p_one", 16'hFC00, 16'h3C00, 1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0);
      step("one_m_inf",  16'h3C00, 16'h7C00, 1'b1, 1'b0, 22'h000000, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0);
      step("nan_p_one",  16'h7E00, 16'h3C00, 1'b0, 1'b0, 22'h000000, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1);

      // Reset toggled mid-stimulus must not disturb the combinational result.
      rst = 1'b1;
      step("rst_hi_2m3", 16'h4000, 16'h4200, 1'b1, 1'b1, 22'h080000, 1'b1, 1'b0, 5'd16, 1'b0, 1'b0);
      rst = 1'b0;
      step("rst_lo_2m3", 16'h4000, 16'h4200, 1'b1, 1'b1, 22'h080000, 1'b1, 1'b0, 5'd16, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
